fetch_sequencer: RTL and testbench

Sequences the program counter for the soft processor's instruction fetch. Issues one instruction-memory request per instruction, waits for the acknowledge, and computes the next PC: sequential, relative jump, call or return. A parameterised return-address stack (RAS) supports call and return. Sits between the control unit (branch, call, ret, stall, halt) and instruction memory, and owns the only architectural PC register.

---
 rtl/fetch_sequencer_if.sv | 13 +
 rtl/fetch_sequencer.sv | 123 ++++++++++++
 tb/tb_fetch_sequencer.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory fetch bus between the fetch sequencer (master) and
// instruction memory (slave).
interface fetch_sequencer_if;
  // Handshake: imem_req is high only while the sequencer waits for an
  // instruction and is not stalled; imem_ack is taken as "data for
  // imem_addr is available" only in a cycle where imem_req is high.
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;

  modport master (output imem_req, output imem_addr, input imem_ack);
  modport slave  (input imem_req, input imem_addr, output imem_ack);
endinterface

// File: rtl/fetch_sequencer.sv
// Program-counter sequencer for instruction fetch: request/ack handshake,
// relative jumps, and call/return through a circular return-address stack.
module fetch_sequencer #(
  parameter int          RAS_DEPTH = 4,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic                halt,
  input  logic                jump,
  input  logic [31:0]         jump_off,
  input  logic                call,
  input  logic                ret,
  fetch_sequencer_if.master   bus,
  output logic [31:0]         pc,
  output logic                instr_valid,
  output logic                ras_empty,
  output logic                ras_full,
  output logic                ras_err,
  output logic [1:0]          dbg_state  // 0 IDLE, 1 REQ, 2 ISSUE, 3 HALTED
);

  localparam int             SPW       = $clog2(RAS_DEPTH);
  localparam logic [SPW-1:0] SP_ONE    = 1;
  localparam logic [SPW:0]   CNT_ONE   = 1;
  localparam logic [SPW:0]   DEPTH_CNT = RAS_DEPTH[SPW:0];

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    ISSUE  = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t         state, state_nxt;
  logic [31:0]    pc_nxt;
  logic [31:0]    pc_inc;
  logic [31:0]    target;
  logic [31:0]    ras_top;
  logic [31:0]    ras_mem [RAS_DEPTH];
  logic [SPW-1:0] sp;   // next free slot; top of stack is sp-1
  logic [SPW:0]   cnt;
  logic           do_push, do_pop, ras_fault, fetch_done;

  assign pc_inc  = pc + 32'd1;
  // Negative offsets are one's-complement encoded, hence the +1 when bit 31 is set.
  assign target  = pc + jump_off + {31'd0, jump_off[31]};
  assign ras_top = ras_mem[sp - SP_ONE];

  assign ras_empty  = (cnt == '0);
  assign ras_full   = (cnt == DEPTH_CNT);
  assign fetch_done = (state == REQ) && bus.imem_ack && !stall;

  assign bus.imem_req  = (state == REQ) && !stall;
  assign bus.imem_addr = pc;
  assign dbg_state     = state;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    do_push   = 1'b0;
    do_pop    = 1'b0;
    ras_fault = 1'b0;
    case (state)
      IDLE:   if (!stall) state_nxt = REQ;
      REQ:    if (fetch_done) state_nxt = ISSUE;
      ISSUE: begin
        if (!stall) begin
          state_nxt = halt ? HALTED : REQ;
          if (ret) begin
            if (ras_empty) begin
              pc_nxt    = pc_inc;
              ras_fault = 1'b1;
            end else begin
              pc_nxt = ras_top;
              do_pop = 1'b1;
            end
          end else if (call) begin
            pc_nxt    = target;
            do_push   = 1'b1;
            ras_fault = ras_full;
          end else if (jump) begin
            pc_nxt = target;
          end else begin
            pc_nxt = pc_inc;
          end
        end
      end
      HALTED: state_nxt = HALTED;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr_valid <= 1'b0;
      sp          <= '0;
      cnt         <= '0;
      ras_err     <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      instr_valid <= fetch_done;
      if (ras_fault) ras_err <= 1'b1;
      // A push onto a full stack overwrites the oldest entry; the count saturates.
      if (do_push) begin
        sp <= sp + SP_ONE;
        if (!ras_full) cnt <= cnt + CNT_ONE;
      end else if (do_pop) begin
        sp  <= sp - SP_ONE;
        cnt <= cnt - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && do_push) ras_mem[sp] <= pc_inc;
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: reset, fetch cadence, a table of
// jump/call/ret vectors, then stall, mid-request reset and halt sequences.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, stall, halt, jump, call, ret;
  logic [31:0] jump_off;
  logic [31:0] pc;
  logic        instr_valid, ras_empty, ras_full, ras_err;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;
  int valid_cnt = 0;
  logic [31:0] exp_q[$];

  localparam logic [1:0] S_IDLE = 2'd0, S_REQ = 2'd1, S_ISSUE = 2'd2, S_HALTED = 2'd3;

  fetch_sequencer_if bus ();

  fetch_sequencer #(.RAS_DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .halt        (halt),
    .jump        (jump),
    .jump_off    (jump_off),
    .call        (call),
    .ret         (ret),
    .bus         (bus),
    .pc          (pc),
    .instr_valid (instr_valid),
    .ras_empty   (ras_empty),
    .ras_full    (ras_full),
    .ras_err     (ras_err),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(negedge clk) if (instr_valid) valid_cnt++;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctrl();
    jump = 1'b0; call = 1'b0; ret = 1'b0; halt = 1'b0; jump_off = 32'h0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_issue(input int limit);
    int n = 0;
    while (instr_valid !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
    checks++;
    if (instr_valid !== 1'b1) begin
      errors++;
      $display("FAIL wait_issue: got no instr_valid within %0d cycles expected a strobe", limit);
    end
  endtask

  typedef struct {
    logic        ret, call, jump;
    logic [31:0] off, pc_at, pc_next;
    logic        empty, full, err;
  } vec_t;

  vec_t vecs[23];

  initial begin
    // ret call jump  off           pc_at         pc_next       empty full err
    vecs[0]  = '{1'b0,1'b0,1'b1, 32'd7,        32'd3,        32'd10,       1'b1,1'b0,1'b0};
    vecs[1]  = '{1'b0,1'b0,1'b1, 32'd5,        32'd10,       32'd15,       1'b1,1'b0,1'b0};
    vecs[2]  = '{1'b0,1'b0,1'b1, 32'hFFFFFFFB, 32'd15,       32'd11,       1'b1,1'b0,1'b0};
    vecs[3]  = '{1'b0,1'b0,1'b1, 32'hFFFFFFF8, 32'd11,       32'd4,        1'b1,1'b0,1'b0};
    vecs[4]  = '{1'b0,1'b1,1'b0, 32'd10,       32'd4,        32'd14,       1'b0,1'b0,1'b0};
    vecs[5]  = '{1'b1,1'b0,1'b0, 32'd0,        32'd14,       32'd5,        1'b1,1'b0,1'b0};
    vecs[6]  = '{1'b0,1'b0,1'b1, 32'hFFFFFFF9, 32'd5,        32'hFFFFFFFF, 1'b1,1'b0,1'b0};
    vecs[7]  = '{1'b0,1'b0,1'b0, 32'd0,        32'hFFFFFFFF, 32'd0,        1'b1,1'b0,1'b0};
    vecs[8]  = '{1'b0,1'b0,1'b1, 32'hFFFFFFFE, 32'd0,        32'hFFFFFFFF, 1'b1,1'b0,1'b0};
    vecs[9]  = '{1'b0,1'b0,1'b1, 32'd2,        32'hFFFFFFFF, 32'd1,        1'b1,1'b0,1'b0};
    vecs[10] = '{1'b0,1'b1,1'b0, 32'd16,       32'd1,        32'd17,       1'b0,1'b0,1'b0};
    vecs[11] = '{1'b0,1'b1,1'b0, 32'd16,       32'd17,       32'd33,       1'b0,1'b0,1'b0};
    vecs[12] = '{1'b0,1'b1,1'b0, 32'd16,       32'd33,       32'd49,       1'b0,1'b0,1'b0};
    vecs[13] = '{1'b0,1'b1,1'b0, 32'd16,       32'd49,       32'd65,       1'b0,1'b1,1'b0};
    vecs[14] = '{1'b0,1'b1,1'b0, 32'd16,       32'd65,       32'd81,       1'b0,1'b1,1'b1};
    vecs[15] = '{1'b1,1'b0,1'b0, 32'd0,        32'd81,       32'd66,       1'b0,1'b0,1'b1};
    vecs[16] = '{1'b1,1'b0,1'b0, 32'd0,        32'd66,       32'd50,       1'b0,1'b0,1'b1};
    vecs[17] = '{1'b1,1'b0,1'b0, 32'd0,        32'd50,       32'd34,       1'b0,1'b0,1'b1};
    vecs[18] = '{1'b1,1'b0,1'b0, 32'd0,        32'd34,       32'd18,       1'b1,1'b0,1'b1};
    vecs[19] = '{1'b1,1'b0,1'b0, 32'd0,        32'd18,       32'd19,       1'b1,1'b0,1'b1};
    vecs[20] = '{1'b1,1'b1,1'b1, 32'd100,      32'd19,       32'd20,       1'b1,1'b0,1'b1};
    vecs[21] = '{1'b0,1'b1,1'b1, 32'hFFFFFFFF, 32'd20,       32'd20,       1'b0,1'b0,1'b1};
    vecs[22] = '{1'b1,1'b0,1'b1, 32'd100,      32'd20,       32'd21,       1'b1,1'b0,1'b1};

    rst_n = 1'b0; stall = 1'b0; bus.imem_ack = 1'b0;
    clear_ctrl();
    tick();
    tick();

    check("reset_pc", pc, 32'h0);
    check("reset_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
    check("reset_req", {31'd0, bus.imem_req}, 32'd0);
    check("reset_valid", {31'd0, instr_valid}, 32'd0);
    check("reset_empty", {31'd0, ras_empty}, 32'd1);
    check("reset_full", {31'd0, ras_full}, 32'd0);
    check("reset_err", {31'd0, ras_err}, 32'd0);

    // Zero-wait memory: strobes in cycles 3,5,7,9 after the release edge.
    rst_n = 1'b1;
    bus.imem_ack = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      int cyc;
      tick();
      cyc = c + 1;
      check($sformatf("cadence_valid_c%0d", cyc), {31'd0, instr_valid}, {31'd0, (cyc % 2) == 1});
      if ((cyc % 2) == 1) check($sformatf("cadence_pc_c%0d", cyc), pc, (cyc - 3) / 2);
    end

    for (int i = 0; i < 23; i++) begin
      wait_issue(8);
      check($sformatf("vec%0d_pc", i), pc, vecs[i].pc_at);
      ret = vecs[i].ret; call = vecs[i].call; jump = vecs[i].jump; jump_off = vecs[i].off;
      exp_q.push_back(vecs[i].pc_next);
      tick();
      clear_ctrl();
      check($sformatf("vec%0d_addr", i), bus.imem_addr, exp_q.pop_front());
      check($sformatf("vec%0d_state", i), {30'd0, dbg_state}, {30'd0, S_REQ});
      check($sformatf("vec%0d_empty", i), {31'd0, ras_empty}, {31'd0, vecs[i].empty});
      check($sformatf("vec%0d_full", i), {31'd0, ras_full}, {31'd0, vecs[i].full});
      check($sformatf("vec%0d_err", i), {31'd0, ras_err}, {31'd0, vecs[i].err});
    end

    // Stall in REQ (ack present but ignored), 3-cycle ack delay, stall in ISSUE.
    begin
      int v0;
      v0 = valid_cnt;
      stall = 1'b1;
      #1;
      check("stall_req_drop", {31'd0, bus.imem_req}, 32'd0);
      for (int k = 0; k < 2; k++) begin
        tick();
        check($sformatf("stall_req_state%0d", k), {30'd0, dbg_state}, {30'd0, S_REQ});
        check($sformatf("stall_req_req%0d", k), {31'd0, bus.imem_req}, 32'd0);
        check($sformatf("stall_req_pc%0d", k), pc, 32'd21);
        check($sformatf("stall_req_valid%0d", k), {31'd0, instr_valid}, 32'd0);
      end
      stall = 1'b0;
      bus.imem_ack = 1'b0;
      #1;
      check("reissue_req", {31'd0, bus.imem_req}, 32'd1);
      tick();
      tick();
      check("ack_wait_state", {30'd0, dbg_state}, {30'd0, S_REQ});
      bus.imem_ack = 1'b1;
      tick();
      bus.imem_ack = 1'b0;
      check("late_ack_valid", {31'd0, instr_valid}, 32'd1);
      check("late_ack_pc", pc, 32'd21);
      stall = 1'b1;
      jump = 1'b1;
      jump_off = 32'd5;
      for (int k = 0; k < 2; k++) begin
        tick();
        check($sformatf("stall_issue_state%0d", k), {30'd0, dbg_state}, {30'd0, S_ISSUE});
        check($sformatf("stall_issue_valid%0d", k), {31'd0, instr_valid}, 32'd0);
        check($sformatf("stall_issue_pc%0d", k), pc, 32'd21);
      end
      stall = 1'b0;
      tick();
      clear_ctrl();
      check("post_stall_addr", bus.imem_addr, 32'd26);
      check("one_valid_per_instr", valid_cnt - v0, 32'd1);
    end

    // Reset while in REQ with ack high the same cycle.
    bus.imem_ack = 1'b1;
    rst_n = 1'b0;
    tick();
    check("mid_rst_pc", pc, 32'h0);
    check("mid_rst_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
    check("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
    check("mid_rst_err", {31'd0, ras_err}, 32'd0);
    check("mid_rst_empty", {31'd0, ras_empty}, 32'd1);
    rst_n = 1'b1;
    tick();
    check("post_rst_state", {30'd0, dbg_state}, {30'd0, S_REQ});
    check("post_rst_valid", {31'd0, instr_valid}, 32'd0);

    // Halt retires the current instruction, then the PC freezes.
    wait_issue(4);
    halt = 1'b1;
    tick();
    clear_ctrl();
    check("halt_state", {30'd0, dbg_state}, {30'd0, S_HALTED});
    for (int k = 0; k < 20; k++) begin
      tick();
      check($sformatf("halt_req%0d", k), {31'd0, bus.imem_req}, 32'd0);
      check($sformatf("halt_pc%0d", k), pc, 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
